// File: rtl/jk_drv_pkg.sv
// -----------------------------------------------------------------------------
// jk_drv_pkg
// Shared definitions for the JK excitation driver:
//   - state_t   : controller states (idle / driving J,K / checking Q)
//   - JK_*      : two-bit {J,K} drive codes
// Imported by jk_excite and jk_excitation_driver.
// -----------------------------------------------------------------------------
package jk_drv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   // {J,K} encodings as seen by a JK flip-flop
   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excitation_driver_excite.sv
// -----------------------------------------------------------------------------
// jk_excite
// Pure combinational excitation mapper: target Q and current Q -> {J,K}.
// Configuration macro: JK_TOGGLE_EN
//   undefined : set/reset excitation, current Q ignored, J=K=1 never produced
//   defined   : toggle when current Q differs from target, hold otherwise
// Ports:
//   tgt_bit  in  desired Q value
//   q_cur    in  current Q of the driven flip-flop
//   jk       out {J,K} code
// -----------------------------------------------------------------------------
module jk_excite
   import jk_drv_pkg::*;
(
   input  logic       tgt_bit,
   input  logic       q_cur,
   output logic [1:0] jk
);

`ifdef JK_TOGGLE_EN
   always_comb begin
      jk = (q_cur != tgt_bit) ? JK_TOGGLE : JK_HOLD;
   end
`else
   // Current Q plays no part in set/reset excitation.
   logic unused_q_cur;
   assign unused_q_cur = q_cur;

   always_comb begin
      jk = tgt_bit ? JK_SET : JK_RESET;
   end
`endif

endmodule

// File: rtl/jk_excitation_driver.sv
// -----------------------------------------------------------------------------
// jk_excitation_driver
// Accepts target Q values over valid/ready, drives J/K of a downstream JK
// flip-flop for HOLD_CYCLES clocks, then reads Q back and reports match or
// mismatch, keeping a saturating mismatch count.
// Configuration macro: JK_TOGGLE_EN (toggle-based excitation, see jk_excite).
// Parameters:
//   HOLD_CYCLES  clocks J/K are presented per target (>= 1)
//   ERR_W        width of the mismatch counter
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   tgt_valid    target present          tgt_bit   desired Q
//   tgt_ready    accepting (IDLE only, combinational from state)
//   q_in         Q readback
//   J, K         registered J/K drive
//   busy         high in DRIVE or CHECK
//   done         one-cycle pulse when a check completes
//   match        result of last check (valid with done, held afterwards)
//   err_cnt      saturating mismatch count
// -----------------------------------------------------------------------------
module jk_excitation_driver
   import jk_drv_pkg::*;
#(
   parameter int HOLD_CYCLES = 3,
   parameter int ERR_W       = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   input  logic             q_in,
   output logic             J,
   output logic             K,
   output logic             busy,
   output logic             done,
   output logic             match,
   output logic [ERR_W-1:0] err_cnt
);

   // HOLD_CYCLES-1 must fit in the counter
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [1:0]       jk_q,    jk_d;
   logic             tgt_q,   tgt_d;
   logic             done_q,  done_d;
   logic             match_q, match_d;
   logic             busy_q,  busy_d;
   logic [ERR_W-1:0] err_q,   err_d;
   logic [1:0]       jk_exc;

   jk_excite u_excite (
      .tgt_bit (tgt_bit),
      .q_cur   (q_in),
      .jk      (jk_exc)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      jk_d    = jk_q;
      tgt_d   = tgt_q;
      done_d  = 1'b0;
      match_d = match_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            // tgt_ready is implied by being in IDLE
            if (tgt_valid) begin
               tgt_d   = tgt_bit;
               jk_d    = jk_exc;
               cnt_d   = CNT_LOAD;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == '0) begin
               jk_d    = JK_HOLD;
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
`ifdef JK_TOGGLE_EN
               // A toggle must last exactly one clock, so J/K drop to hold
               // after the first DRIVE edge.
               jk_d  = JK_HOLD;
`endif
            end
         end
         ST_CHECK: begin
            done_d  = 1'b1;
            match_d = (q_in == tgt_q);
            if ((q_in != tgt_q) && (err_q != '1)) begin
               err_d = err_q + ERR_W'(1);
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         jk_q    <= JK_HOLD;
         tgt_q   <= 1'b0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         jk_q    <= jk_d;
         tgt_q   <= tgt_d;
         done_q  <= done_d;
         match_q <= match_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign tgt_ready = (state_q == ST_IDLE);
   assign J         = jk_q[1];
   assign K         = jk_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign match     = match_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // DUT A: ERR_W=8, drives a bench JK flip-flop (or a stuck-0 Q when q_sel=1)
   logic       a_valid = 1'b0, a_bit = 1'b0, a_ready;
   logic       a_J, a_K, a_busy, a_done, a_match;
   logic [7:0] a_err;
   logic       q_sel = 1'b0;
   logic       ff_q;
   logic       a_q_in;
   assign a_q_in = q_sel ? 1'b0 : ff_q;

   // DUT B: ERR_W=2, Q stuck at 0, used for saturation
   logic       b_valid = 1'b0, b_bit = 1'b0, b_ready;
   logic       b_J, b_K, b_busy, b_done, b_match;
   logic [1:0] b_err;

   jk_excitation_driver #(.HOLD_CYCLES(3), .ERR_W(8)) dut_a (
      .clk(clk), .rst(rst), .tgt_valid(a_valid), .tgt_bit(a_bit),
      .tgt_ready(a_ready), .q_in(a_q_in), .J(a_J), .K(a_K),
      .busy(a_busy), .done(a_done), .match(a_match), .err_cnt(a_err)
   );

   jk_excitation_driver #(.HOLD_CYCLES(3), .ERR_W(2)) dut_b (
      .clk(clk), .rst(rst), .tgt_valid(b_valid), .tgt_bit(b_bit),
      .tgt_ready(b_ready), .q_in(1'b0), .J(b_J), .K(b_K),
      .busy(b_busy), .done(b_done), .match(b_match), .err_cnt(b_err)
   );

   // Downstream JK flip-flop driven by DUT A
   always_ff @(posedge clk) begin
      if (rst) ff_q <= 1'b0;
      else begin
         case ({a_J, a_K})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end

   // Handshake and done-pulse counters for DUT A
   int a_acc_cnt  = 0;
   int a_done_cnt = 0;
   always @(posedge clk) begin
      if (a_valid && a_ready) a_acc_cnt++;
      if (a_done) a_done_cnt++;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Present one target and return #1 after its accept edge.
   task automatic accept(input bit use_b, input logic b);
      int n;
      n = 0;
      if (use_b) begin b_valid = 1'b1; b_bit = b; end
      else       begin a_valid = 1'b1; a_bit = b; end
      while ((use_b ? b_ready : a_ready) !== 1'b1 && n < 20) begin
         step(1);
         n++;
      end
      total++;
      if (n >= 20) begin
         $display("FAIL accept_timeout use_b=%0d ready never rose within %0d cycles", use_b, n);
         bad++;
      end
      step(1);
      if (use_b) b_valid = 1'b0;
      else       a_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      total++;
      if ({a_J, a_K, a_busy, a_done, a_match, a_err, a_ready} !== {5'b0, 8'd0, 1'b1}) begin
         $display("FAIL reset_init got J=%b K=%b busy=%b done=%b match=%b err=%0d ready=%b want 0,0,0,0,0,0,1",
                  a_J, a_K, a_busy, a_done, a_match, a_err, a_ready);
         bad++;
      end
      accept(1'b0, 1'b1);
      step(1);
      total++;
      if (a_J !== 1'b1 || a_busy !== 1'b1) begin
         $display("FAIL reset_predrive got J=%b busy=%b want J=1 busy=1", a_J, a_busy);
         bad++;
      end
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      total++;
      if ({a_J, a_K, a_busy, a_err, a_ready, a_done} !== {3'b0, 8'd0, 1'b1, 1'b0}) begin
         $display("FAIL reset_middrive got J=%b K=%b busy=%b err=%0d ready=%b done=%b want 0,0,0,0,1,0",
                  a_J, a_K, a_busy, a_err, a_ready, a_done);
         bad++;
      end
      step(1);
      total++;
      if (a_busy !== 1'b0 || a_ready !== 1'b1) begin
         $display("FAIL reset_stays_idle got busy=%b ready=%b want 0,1", a_busy, a_ready);
         bad++;
      end
   endtask

   task automatic test_set_reset();
      logic       tv [3] = '{1'b1, 1'b0, 1'b1};
      logic [1:0] exp_jk;
      q_sel = 1'b0;
      for (int t = 0; t < 3; t++) begin
         exp_jk = tv[t] ? 2'b10 : 2'b01;
         accept(1'b0, tv[t]);
         for (int c = 0; c < 3; c++) begin
            total++;
            if ({a_J, a_K} !== exp_jk || a_busy !== 1'b1 || a_done !== 1'b0) begin
               $display("FAIL setrst_drive t=%0d c=%0d got JK=%b%b busy=%b done=%b want JK=%b busy=1 done=0",
                        t, c, a_J, a_K, a_busy, a_done, exp_jk);
               bad++;
            end
            step(1);
         end
         total++;
         if ({a_J, a_K} !== 2'b00 || a_done !== 1'b0 || a_busy !== 1'b1) begin
            $display("FAIL setrst_check t=%0d got JK=%b%b done=%b busy=%b want JK=00 done=0 busy=1",
                     t, a_J, a_K, a_done, a_busy);
            bad++;
         end
         step(1);
         total++;
         if (a_done !== 1'b1 || a_match !== 1'b1 || a_err !== 8'd0 || a_busy !== 1'b0) begin
            $display("FAIL setrst_done t=%0d got done=%b match=%b err=%0d busy=%b want 1,1,0,0",
                     t, a_done, a_match, a_err, a_busy);
            bad++;
         end
      end
      step(1);
      total++;
      if (a_done !== 1'b0 || a_match !== 1'b1) begin
         $display("FAIL setrst_pulse got done=%b match=%b want done=0 match=1", a_done, a_match);
         bad++;
      end
   endtask

   task automatic test_toggle();
      q_sel = 1'b0;
      // Q is 0 after reset, so the first target 1 needs a toggle
      accept(1'b0, 1'b1);
      total++;
      if ({a_J, a_K} !== 2'b11) begin
         $display("FAIL toggle_first got JK=%b%b want 11", a_J, a_K);
         bad++;
      end
      for (int c = 0; c < 3; c++) begin
         step(1);
         total++;
         if ({a_J, a_K} !== 2'b00) begin
            $display("FAIL toggle_rest c=%0d got JK=%b%b want 00", c, a_J, a_K);
            bad++;
         end
      end
      step(1);
      total++;
      if (a_done !== 1'b1 || a_match !== 1'b1) begin
         $display("FAIL toggle_done1 got done=%b match=%b want 1,1", a_done, a_match);
         bad++;
      end
      accept(1'b0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         total++;
         if ({a_J, a_K} !== 2'b00) begin
            $display("FAIL toggle_hold c=%0d got JK=%b%b want 00", c, a_J, a_K);
            bad++;
         end
         step(1);
      end
      total++;
      if (a_done !== 1'b1 || a_match !== 1'b1) begin
         $display("FAIL toggle_done2 got done=%b match=%b want 1,1", a_done, a_match);
         bad++;
      end
      step(1);
   endtask

   task automatic test_backpressure();
      int acc0, done0;
      q_sel = 1'b0;
      acc0  = a_acc_cnt;
      done0 = a_done_cnt;
      a_valid = 1'b1;
      a_bit   = 1'b0;
      step(1);                       // accept edge
      for (int c = 0; c < 4; c++) begin
         total++;
         if (a_ready !== 1'b0) begin
            $display("FAIL bp_ready c=%0d got ready=%b want 0", c, a_ready);
            bad++;
         end
         step(1);
      end
      total++;
      if (a_ready !== 1'b1 || a_done !== 1'b1 || a_match !== 1'b1) begin
         $display("FAIL bp_release got ready=%b done=%b match=%b want 1,1,1", a_ready, a_done, a_match);
         bad++;
      end
      a_valid = 1'b0;
      step(3);
      total++;
      if (a_acc_cnt - acc0 !== 1 || a_done_cnt - done0 !== 1) begin
         $display("FAIL bp_once got accepts=%0d dones=%0d want 1,1", a_acc_cnt - acc0, a_done_cnt - done0);
         bad++;
      end
   endtask

   task automatic test_mismatch();
      q_sel = 1'b1;
      for (int t = 0; t < 3; t++) begin
         accept(1'b0, 1'b1);
         step(4);
         total++;
         if (a_done !== 1'b1 || a_match !== 1'b0 || a_err !== 8'(t + 1)) begin
            $display("FAIL mismatch t=%0d got done=%b match=%b err=%0d want 1,0,%0d",
                     t, a_done, a_match, a_err, t + 1);
            bad++;
         end
      end
      step(1);
      total++;
      if (a_err !== 8'd3 || a_match !== 1'b0) begin
         $display("FAIL mismatch_final got err=%0d match=%b want 3,0", a_err, a_match);
         bad++;
      end
      q_sel = 1'b0;
   endtask

   task automatic test_saturation();
      logic [1:0] exp_err;
      total++;
      if (b_err !== 2'd0 || b_ready !== 1'b1) begin
         $display("FAIL sat_start got err=%0d ready=%b want 0,1", b_err, b_ready);
         bad++;
      end
      for (int t = 0; t < 6; t++) begin
         exp_err = (t >= 2) ? 2'd3 : 2'(t + 1);
         accept(1'b1, 1'b1);
         step(4);
         total++;
         if (b_done !== 1'b1 || b_match !== 1'b0 || b_err !== exp_err) begin
            $display("FAIL saturation t=%0d got done=%b match=%b err=%0d want 1,0,%0d",
                     t, b_done, b_match, b_err, exp_err);
            bad++;
         end
      end
   endtask

   initial begin
      step(1);
      test_reset();
`ifdef JK_TOGGLE_EN
      test_toggle();
`else
      test_set_reset();
`endif
      test_backpressure();
      test_mismatch();
      test_saturation();
      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
